store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// ----------------------------------------------------------------------------
// store_buffer
//
// Purpose:
//   Post-commit store buffer between the MEM stage and data memory. Stores are
//   queued in a circular FIFO and drained to memory one at a time, oldest
//   first, under a two-state drain FSM (IDLE / WRITE). Stores are never merged
//   or reordered. Optional store-to-load forwarding returns the youngest
//   buffered store whose word address matches a load lookup.
//
// Configuration:
//   STORE_BUFFER_FWD_EN  - when defined, enables combinational store-to-load
//                          forwarding. When undefined, fwd_hit and fwd_data
//                          are tied to zero and no compare logic is built.
//
// Parameters:
//   DEPTH     - number of buffered entries (power of two, 2..16)
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - asynchronous active-high reset, discards all entries
//   wmem      - store request from the MEM stage
//   addr      - store byte address (bits [1:0] ignored, word stores only)
//   di        - store data
//   full      - buffer holds DEPTH entries (pipeline stalls on it)
//   empty     - buffer holds zero entries
//   count     - current entry count
//   mem_we    - write request to data memory (high exactly in WRITE)
//   mem_addr  - head-entry word address, bits [1:0] = 0
//   mem_di    - head-entry data
//   mem_ack   - memory accepted the current write
//   ld_req    - load lookup from the MEM stage
//   ld_addr   - load byte address
//   fwd_hit   - load word address matches a buffered store
//   fwd_data  - data of the youngest matching store, 0 when no hit
// ----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wmem,
    input  logic [31:0] addr,
    input  logic [31:0] di,
    output logic        full,
    output logic        empty,
    output logic [4:0]  count,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_di,
    input  logic        mem_ack,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Only the word address is stored; bits [1:0] are always zero on output.
    logic [29:0]      r_addr_mem [DEPTH];
    logic [31:0]      r_data_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [4:0]       r_count;
    state_t           r_state;
    logic             r_mem_we;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic       w_full;
    logic       w_empty;
    logic       w_enq;
    logic       w_retire;
    logic [4:0] w_count_nxt;

    // full/empty come from the registered count only, so a store arriving
    // while full is refused even if the head retires on the same edge.
    assign w_full   = (r_count == DEPTH_C);
    assign w_empty  = (r_count == 5'd0);
    assign w_enq    = wmem & ~w_full;
    // mem_ack only matters while a write is actually being presented.
    assign w_retire = r_mem_we & mem_ack;

    assign w_count_nxt = r_count + 5'(w_enq) - 5'(w_retire);

    // ------------------------------------------------------------------------
    // Pointers, count and drain FSM
    // ------------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples pre-edge values; blocking here would let later
    // statements see already-updated pointers and mis-order the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_state  <= IDLE;
            r_mem_we <= 1'b0;
        end else begin
            if (w_enq)
                r_tail <= r_tail + PTR_W'(1);
            if (w_retire)
                r_head <= r_head + PTR_W'(1);
            r_count <= w_count_nxt;

            // The FSM looks at the next count so that the first write is
            // presented on the cycle right after an enqueue into an empty
            // buffer, and WRITE is left only when the last entry retires
            // without a same-cycle enqueue refilling it.
            case (r_state)
                IDLE: begin
                    if (w_count_nxt != 5'd0) begin
                        r_state  <= WRITE;
                        r_mem_we <= 1'b1;
                    end
                end
                WRITE: begin
                    if (w_count_nxt == 5'd0) begin
                        r_state  <= IDLE;
                        r_mem_we <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------------
    // NOTE: the storage array is deliberately not reset; slot validity is
    // tracked by head/tail/count, and every output that reads the array is
    // gated so stale contents never leak out after reset.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr_mem[r_tail] <= addr[31:2];
            r_data_mem[r_tail] <= di;
        end
    end

    // ------------------------------------------------------------------------
    // Memory-side outputs
    // ------------------------------------------------------------------------
    // The head slot cannot be overwritten while a write is pending: tail only
    // equals head when the buffer is empty (no write) or full (no enqueue),
    // so mem_addr/mem_di hold steady under backpressure.
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_we ? {r_addr_mem[r_head], 2'b00} : 32'h0;
    assign mem_di   = r_mem_we ? r_data_mem[r_head] : 32'h0;

    assign full  = w_full;
    assign empty = w_empty;
    assign count = r_count;

    // ------------------------------------------------------------------------
    // Store-to-load forwarding
    // ------------------------------------------------------------------------
`ifdef STORE_BUFFER_FWD_EN
    logic        w_fwd_hit;
    logic [31:0] w_fwd_data;

    // Walk the valid entries from oldest to youngest; a later match
    // overrides an earlier one, so the youngest matching store wins.
    // NOTE: every always_comb output gets a default before the loop;
    // without it a path with no match would infer a latch.
    always_comb begin
        logic [PTR_W-1:0] w_slot;
        w_fwd_hit  = 1'b0;
        w_fwd_data = 32'h0;
        w_slot     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot = r_head + PTR_W'(k);
            if (ld_req && (5'(k) < r_count) &&
                (r_addr_mem[w_slot] == ld_addr[31:2])) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data_mem[w_slot];
            end
        end
    end

    assign fwd_hit  = w_fwd_hit;
    assign fwd_data = w_fwd_data;

    // Byte-offset bits take no part in the word-granular match.
    logic w_unused;
    assign w_unused = ^{addr[1:0], ld_addr[1:0]};
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = 32'h0;

    // Lookup inputs are intentionally unconnected in this build.
    logic w_unused;
    assign w_unused = ^{addr[1:0], ld_req, ld_addr};
`endif

endmodule
